// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : Moore control FSM for a multicycle MIPS-style datapath.
// Optional MEM_READY_EN: FETCH/MEM_READ/MEM_WRITE wait for mem_ready_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode_i,
  input  logic [5:0]             funct_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic [2:0]             alu_op_o,
  output logic                   alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [1:0]             pc_src_o,
  output logic                   pc_en_o,
  output logic                   ir_write_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   i_or_d_o,
  output logic                   reg_write_o,
  output logic                   mem_to_reg_o,
  output logic                   reg_dst_o,
  output logic                   instr_done_o,
  output logic                   illegal_o,
  output logic [3:0]             state_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_EXEC_I    = 4'd10,
    ST_I_WB      = 4'd11,
    ST_JR        = 4'd12
  } state_t;

  state_t                 state_q, state_d;
  logic [5:0]             opcode_q, opcode_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ready;

`ifdef MEM_READY_EN
  assign ready = mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign ready = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    alu_op_o     = 3'b000;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    pc_src_o     = 2'b00;
    pc_en_o      = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        ir_write_o  = ready;
        alu_src_b_o = 2'b01;
        alu_op_o    = 3'b100;
        pc_en_o     = ready;
        if (ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = 3'b100;
        opcode_d    = opcode_i;
        case (opcode_i)
          6'h23, 6'h2B:               state_d = ST_MEM_ADDR;
          6'h00:                      state_d = (funct_i == 6'h08) ? ST_JR : ST_EXEC_R;
          6'h04, 6'h05:               state_d = ST_BRANCH;
          6'h02:                      state_d = ST_JUMP;
          6'h08, 6'h0C, 6'h0D, 6'h0F: state_d = ST_EXEC_I;
          default: begin
            illegal_o = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 3'b100;
        state_d     = (opcode_q == 6'h2B) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        i_or_d_o     = 1'b1;
        mem_write_o  = ready;
        instr_done_o = ready;
        if (ready) state_d = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b111;
        state_d     = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_q)
          6'h0C:   alu_op_o = 3'b010;
          6'h0D:   alu_op_o = 3'b001;
          6'h0F:   alu_op_o = 3'b000;
          default: alu_op_o = 3'b100;
        endcase
        state_d = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = 3'b011;
        pc_src_o     = 2'b01;
        // opcode bit 0 distinguishes bne (0x05) from beq (0x04)
        pc_en_o      = opcode_q[0] ? ~zero_i : zero_i;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_o     = 2'b10;
        pc_en_o      = 1'b1;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_JR: begin
        pc_src_o     = 2'b11;
        pc_en_o      = 1'b1;
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (reset) begin
      alu_op_o     = 3'b000;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      pc_src_o     = 2'b00;
      pc_en_o      = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_dst_o    = 1'b0;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
    end

    count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, instr_done_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= 6'h00;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  assign state_o       = reset ? 4'd0 : state_q;
  assign instr_count_o = count_q;

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter COUNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode_i  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct_i  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 mem_ready_i  input  1  memory access complete; used only when MEM_READY_EN is defined.
REQ-008 alu_op_o  output  3  ALU-control opcode: 111 R-type, 100 add, 010 and, 001 or, 000 lui, 011 sub/branch.
REQ-009 alu_src_a_o  output  1  ALU A source: 0 PC, 1 register A.
REQ-010 alu_src_b_o  output  2  ALU B source: 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-011 pc_src_o  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A (jr).
REQ-012 pc_en_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o, mem_to_reg_o, reg_dst_o  output  1 each  datapath strobes/selects.
REQ-013 instr_done_o  output  1  one-cycle pulse in the last state of each instruction.
REQ-014 illegal_o  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-015 state_o  output  4  current state encoding.
REQ-016 instr_count_o  output  COUNT_WIDTH  retired-instruction count.

Function
REQ-017 States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11, JR 12; codes 13-15 go to FETCH on the next cycle with all strobes 0.
REQ-018 All outputs are Moore-decoded from the registered state, except pc_en_o in BRANCH and the mem_ready_i gating in REQ-032; any strobe not listed for a state is 0.
REQ-019 FETCH: mem_read=1, i_or_d=0, ir_write=1, src_a=0, src_b=01, alu_op=100, pc_src=00, pc_en=1; next state DECODE.
REQ-020 DECODE: src_a=0, src_b=11, alu_op=100 (branch target to ALUOut); next state by opcode: 0x23/0x2B -> MEM_ADDR, 0x00 with funct 0x08 -> JR, other 0x00 -> EXEC_R, 0x04/0x05 -> BRANCH, 0x02 -> JUMP, 0x08/0x0C/0x0D/0x0F -> EXEC_I, otherwise illegal_o=1 and FETCH.
REQ-021 MEM_ADDR: src_a=1, src_b=10, alu_op=100; next state MEM_READ for 0x23, MEM_WRITE for 0x2B.
REQ-022 MEM_READ: mem_read=1, i_or_d=1 -> MEM_WB; MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
REQ-023 MEM_WRITE: mem_write=1, i_or_d=1, instr_done=1 -> FETCH.
REQ-024 EXEC_R: src_a=1, src_b=00, alu_op=111 -> R_WB; R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
REQ-025 EXEC_I: src_a=1, src_b=10, alu_op per opcode 0x08->100, 0x0C->010, 0x0D->001, 0x0F->000, taken from an opcode register latched in DECODE -> I_WB; I_WB: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
REQ-026 BRANCH: src_a=1, src_b=00, alu_op=011, pc_src=01, pc_en = zero_i for 0x04, ~zero_i for 0x05; instr_done=1 -> FETCH.
REQ-027 JUMP: pc_src=10, pc_en=1, instr_done=1 -> FETCH; JR: pc_src=11, pc_en=1, instr_done=1 -> FETCH.
REQ-028 Latency without wait states: beq/bne/j/jr 3 cycles, R-type/I-type/sw 4, lw 5.
REQ-029 instr_count_o increments by 1 in every cycle instr_done_o=1, wraps from all-ones to 0; illegal opcodes do not increment it.

Reset
REQ-030 While reset=1 at a clock edge: state<=FETCH, latched opcode<=0, instr_count<=0; while reset is high all strobes, alu_op_o, selects and pulses are forced 0 and state_o=0.
REQ-031 Reset asserted mid-instruction aborts it with no instr_done_o pulse; the first cycle after release is FETCH.

Configuration
REQ-032 Macro MEM_READY_EN defined: FETCH, MEM_READ and MEM_WRITE hold their state until mem_ready_i=1; ir_write, pc_en (FETCH) and mem_write/instr_done (MEM_WRITE) assert only in the ready cycle; mem_read stays high throughout.
REQ-033 MEM_READY_EN undefined: mem_ready_i is ignored and each of those states lasts exactly one cycle.

Verification
REQ-034 Reset release, opcode 0x00 funct 0x20 -> states 0,1,6,7,0; alu_op 100,100,111,-; reg_write only in R_WB; instr_count 0->1.
REQ-035 opcode 0x04, zero_i=1 then repeat with zero_i=0 -> pc_en=1 in BRANCH first time, 0 second; both 3 cycles, count +2.
REQ-036 opcode 0x23 with MEM_READY_EN, mem_ready_i low 3 cycles in MEM_READ -> state holds at 3 for 4 cycles total; lw takes 8 cycles; mem_to_reg=1 in MEM_WB.
REQ-037 opcode 0x3F -> illegal_o pulse in DECODE, next state FETCH, count unchanged; opcode 0x00 funct 0x08 -> JR with pc_src=11, pc_en=1.
REQ-038 Preload counter near wrap (COUNT_WIDTH=4, 15 instructions then one more) -> instr_count_o 15 -> 0.
REQ-039 reset asserted in EXEC_I of ori (0x0D) -> no instr_done_o, all outputs 0 during reset, FETCH first cycle after release.
